// File: rtl/cache_monitor.sv
// Cache hit/miss monitor: counts lookups and logs {rw, hit, index, tag, lat}.
// Optional latency counter enabled by defining CACHE_MON_LATENCY_EN.
module cache_monitor #(
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 18,
  parameter int INDEX_W = 10,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16,
  parameter int DEPTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cpu_req_valid,
  input  logic                                  cpu_req_rw,
  input  logic [ADDR_W-1:0]                     cpu_req_addr,
  input  logic                                  cpu_res_ready,
  input  logic                                  tag_read_valid,
  input  logic [TAG_W-1:0]                      tag_read_tag,
  input  logic                                  clear,
  input  logic                                  trace_pop,
  output logic                                  trace_valid,
  output logic [2+INDEX_W+TAG_W+LAT_W-1:0]      trace_data,
  output logic [CNT_W-1:0]                      hit_cnt,
  output logic [CNT_W-1:0]                      miss_cnt,
  output logic                                  overflow,
  output logic                                  busy
);

  localparam int ENTRY_W = 2 + INDEX_W + TAG_W + LAT_W;
  localparam int AW      = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 rw_q, rw_d;
  logic                 hit_q, hit_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic                 overflow_q, overflow_d;
  logic [AW:0]          wptr_q, wptr_d;
  logic [AW:0]          rptr_q, rptr_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];

  logic                 commit;
  logic                 c_hit;
  logic                 lookup_hit;
  logic [LAT_W-1:0]     lat_c;
  logic                 empty, full;
  logic                 pop_en, push_en, drop;
  logic                 addr_unused;

  assign addr_unused = ^cpu_req_addr[ADDR_W-TAG_W-INDEX_W-1:0];
  assign lookup_hit  = tag_read_valid && (tag_read_tag == tag_q);

`ifdef CACHE_MON_LATENCY_EN
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] lat_inc;

  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;

  // The value logged on commit includes the ready cycle itself.
  always_comb begin
    lat_d = lat_q;
    lat_c = lat_q;
    unique case (state_q)
      S_IDLE:  if (cpu_req_valid) lat_d = LAT_W'(1);
      S_WAIT: begin
        lat_d = lat_inc;
        lat_c = lat_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lat_q <= '0;
    else      lat_q <= lat_d;
  end
`else
  assign lat_c = '0;
`endif

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    tag_d   = tag_q;
    index_d = index_q;
    hit_d   = hit_q;
    commit  = 1'b0;
    c_hit   = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          rw_d    = cpu_req_rw;
          tag_d   = cpu_req_addr[ADDR_W-1 -: TAG_W];
          index_d = cpu_req_addr[ADDR_W-TAG_W-1 -: INDEX_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d = lookup_hit;
        c_hit = lookup_hit;
        if (cpu_res_ready) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cpu_res_ready) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  always_comb begin
    pop_en  = trace_pop && !empty;
    push_en = commit && (!full || pop_en);
    drop    = commit && full && !pop_en;
    mem_d   = mem_q;
    if (push_en)
      mem_d[wptr_q[AW-1:0]] = {rw_q, c_hit, index_q, tag_q, lat_c};
    wptr_d = wptr_q + (AW+1)'(push_en);
    rptr_d = rptr_q + (AW+1)'(pop_en);
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    overflow_d = overflow_q | drop;
    if (commit && c_hit && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 1'b1;
    if (commit && !c_hit && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 1'b1;
    if (clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      hit_q      <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      hit_q      <= hit_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
    end
  end

  assign trace_valid = !empty;
  assign trace_data  = mem_q[rptr_q[AW-1:0]];
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_monitor.sv
// Testbench for cache_monitor: vector table, corner sequences and a
// transaction-level reference model driven by random traffic.
module tb_cache_monitor;

  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 18;
  localparam int INDEX_W = 10;
  localparam int LAT_W   = 8;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 2 + INDEX_W + TAG_W + LAT_W;

  typedef logic [ENTRY_W-1:0] entry_t;

  logic               clk;
  logic               rst;
  logic               cpu_req_valid;
  logic               cpu_req_rw;
  logic [ADDR_W-1:0]  cpu_req_addr;
  logic               cpu_res_ready;
  logic               tag_read_valid;
  logic [TAG_W-1:0]   tag_read_tag;
  logic               clear;
  logic               trace_pop;
  logic               trace_valid;
  entry_t             trace_data;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;
  logic               overflow;
  logic               busy;

  cache_monitor #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W),
    .LAT_W(LAT_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_res_ready(cpu_res_ready),
    .tag_read_valid(tag_read_valid), .tag_read_tag(tag_read_tag),
    .clear(clear), .trace_pop(trace_pop),
    .trace_valid(trace_valid), .trace_data(trace_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  entry_t mq[$];
  int     m_hit;
  int     m_miss;
  bit     m_ovf;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    bit          tv;
    logic [17:0] tt;
    int          n;
    bit          hit;
    int          lat;
  } vec_t;

  vec_t vt[5];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(bit rw, bit hit, logic [31:0] addr, int lat);
    logic [7:0] l;
    l = (lat > 255) ? 8'hFF : 8'(lat);
`ifndef CACHE_MON_LATENCY_EN
    l = 8'h00;
`endif
    return {rw, hit, addr[13:4], addr[31:14], l};
  endfunction

  task automatic idle_inputs();
    cpu_req_valid  = 1'b0;
    cpu_req_rw     = 1'b0;
    cpu_req_addr   = '0;
    cpu_res_ready  = 1'b0;
    tag_read_valid = 1'b0;
    tag_read_tag   = '0;
    clear          = 1'b0;
    trace_pop      = 1'b0;
  endtask

  task automatic check_state(string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_hit_cnt"}, hit_cnt, m_hit);
    chk({name, "_miss_cnt"}, miss_cnt, m_miss);
    chk({name, "_overflow"}, overflow, m_ovf);
    chk({name, "_trace_valid"}, trace_valid, mq.size() != 0);
    if (mq.size() != 0) chk({name, "_trace_data"}, trace_data, mq[0]);
  endtask

  task automatic model_reset();
    mq.delete();
    m_hit  = 0;
    m_miss = 0;
    m_ovf  = 0;
  endtask

  // One full request: ready arrives n cycles after the lookup cycle.
  task automatic txn(bit rw, logic [31:0] addr, bit tv, logic [17:0] tt,
                     int n, bit pop, bit clr);
    bit     hit;
    bit     dropped;
    entry_t e;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    @(posedge clk); #1;
    chk("busy_lookup", busy, 1);
    cpu_req_valid  = 1'($urandom);
    cpu_req_rw     = 1'($urandom);
    cpu_req_addr   = $urandom;
    tag_read_valid = tv;
    tag_read_tag   = tt;
    cpu_res_ready  = (n == 0);
    trace_pop      = pop && (n == 0);
    clear          = clr && (n == 0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      tag_read_valid = 1'($urandom);
      tag_read_tag   = 18'($urandom);
      cpu_res_ready  = (i == n);
      trace_pop      = pop && (i == n);
      clear          = clr && (i == n);
    end
    @(posedge clk); #1;
    idle_inputs();
    hit = tv && (tt == addr[31:14]);
    e   = mk(rw, hit, addr, n + 1);
    if (pop && mq.size() != 0) void'(mq.pop_front());
    dropped = (mq.size() >= DEPTH);
    if (!dropped) mq.push_back(e);
    if (clr) begin
      m_hit  = 0;
      m_miss = 0;
      m_ovf  = 0;
    end else begin
      if (hit && m_hit < 65535) m_hit++;
      if (!hit && m_miss < 65535) m_miss++;
      if (dropped) m_ovf = 1;
    end
  endtask

  task automatic pop_one();
    trace_pop = 1'b1;
    @(posedge clk); #1;
    trace_pop = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  initial begin
    entry_t e0;
    logic [31:0] a;
    bit          m;

    vt[0] = '{rw: 0, addr: 32'h0000_4010, tv: 1, tt: 18'h00001, n: 0, hit: 1, lat: 1};
    vt[1] = '{rw: 1, addr: 32'h0000_8020, tv: 1, tt: 18'h00003, n: 5, hit: 0, lat: 6};
    vt[2] = '{rw: 0, addr: 32'h0000_8020, tv: 0, tt: 18'h00002, n: 1, hit: 0, lat: 2};
    vt[3] = '{rw: 1, addr: 32'hFFFF_FFF0, tv: 1, tt: 18'h3FFFF, n: 2, hit: 1, lat: 3};
    vt[4] = '{rw: 0, addr: 32'h1234_5678, tv: 1, tt: 18'h048D0, n: 3, hit: 0, lat: 4};

    idle_inputs();
    model_reset();
    rst = 1'b0;
    #3;
    check_state("reset");
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors; each entry is drained right after it is checked.
    for (int i = 0; i < 5; i++) begin
      txn(vt[i].rw, vt[i].addr, vt[i].tv, vt[i].tt, vt[i].n, 0, 0);
      check_state("vec");
      chk("vec_entry", trace_data,
          mk(vt[i].rw, vt[i].hit, vt[i].addr, vt[i].lat));
      if (i == 0) begin
`ifdef CACHE_MON_LATENCY_EN
        e0 = 38'h10_0400_0101;
`else
        e0 = 38'h10_0400_0100;
`endif
        chk("vec0_literal", trace_data, e0);
      end
      pop_one();
      check_state("vec_pop");
    end

    // Pop on empty FIFO is ignored.
    pop_one();
    check_state("pop_empty");

    // Nine commits without pops: ninth is dropped.
    for (int i = 0; i < 9; i++)
      txn(1'(i), 32'h0000_1000 * i, 1, 18'(i & 1), i % 3, 0, 0);
    check_state("ovf_fill");
    chk("ovf_depth", mq.size(), DEPTH);
    for (int i = 0; i < 8; i++) begin
      check_state("ovf_drain");
      pop_one();
    end
    check_state("ovf_empty");

    // Clear while idle zeroes counters and overflow.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_hit = 0; m_miss = 0; m_ovf = 0;
    check_state("clear_idle");

    // Full FIFO with commit and pop on the same cycle.
    for (int i = 0; i < 8; i++)
      txn(0, 32'h0000_4000 * i, 1, 18'(i), 0, 0, 0);
    txn(1, 32'hABCD_0120, 1, 18'h2AF34, 2, 1, 0);
    check_state("full_pushpop");
    chk("full_depth", mq.size(), DEPTH);
    for (int i = 0; i < 8; i++) begin
      check_state("full_drain");
      pop_one();
    end
    check_state("full_empty");

    // Reset mid-transaction while in WAIT.
    txn(0, 32'h0000_4010, 1, 18'h00001, 0, 0, 0);
    txn(1, 32'h0000_8020, 1, 18'h00000, 1, 0, 0);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_C030;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #2;
    model_reset();
    check_state("rst_wait");
    @(negedge clk);
    rst = 1'b1;
    cpu_res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_res_ready = 1'b0;
    check_state("rst_after");

    // Request presented straight after reset release is taken at once.
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
    txn(0, 32'h0001_0040, 1, 18'h00004, 0, 0, 0);
    check_state("first_after_rst");
    pop_one();

    // Long wait saturates latency; clear on commit wins over the count.
    txn(0, 32'h0000_4010, 0, 18'h00001, 300, 0, 1);
    check_state("lat_sat_clear");
    pop_one();

    // Random traffic against the transaction model.
    for (int k = 0; k < 80; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        a = $urandom;
        m = 1'($urandom);
        txn(1'($urandom), a, 1'($urandom_range(0, 3) != 0),
            m ? a[31:14] : 18'($urandom),
            $urandom_range(0, 6), $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) == 0);
      end else if (r < 95) begin
        pop_one();
      end else begin
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_hit = 0; m_miss = 0; m_ovf = 0;
      end
      check_state("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
